// File: rtl/upscaler_pixel_feeder.sv
// Source-frame reader feeding the bicubic upscaler: each raster pixel is held for H_PHASES valid cycles.
// Optional black-row flush after the frame is compiled in with UPSCALER_FEED_FLUSH_EN.
module upscaler_pixel_feeder #(
    parameter int IMG_W      = 384,
    parameter int IMG_H      = 216,
    parameter int H_PHASES   = 3,
    parameter int ADDR_W     = 17,
    parameter int FLUSH_ROWS = 3
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic              stall,
    output logic              mem_rd_en,
    output logic [ADDR_W-1:0] mem_addr,
    input  logic [23:0]       mem_rd_data,
    output logic [23:0]       pixel_out,
    output logic              pixel_valid,
    output logic              sof,
    output logic              eol,
    output logic              busy,
    output logic              done
);
    localparam int ROW_MAX = (IMG_H > FLUSH_ROWS) ? IMG_H : FLUSH_ROWS;
    localparam int CW = $clog2(IMG_W + 1);
    localparam int RW = $clog2(ROW_MAX + 1);
    localparam int PW = $clog2(H_PHASES + 1);
    localparam logic [CW-1:0] COL_LAST = CW'(IMG_W - 1);
    localparam logic [RW-1:0] ROW_LAST = RW'(IMG_H - 1);
    localparam logic [PW-1:0] PH_LAST  = PW'(H_PHASES - 1);
`ifdef UPSCALER_FEED_FLUSH_EN
    localparam logic [RW-1:0] FL_LAST  = RW'(FLUSH_ROWS - 1);
`endif

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_FETCH = 3'd1,
        S_WAIT  = 3'd2,
        S_EMIT  = 3'd3,
        S_DONE  = 3'd4
`ifdef UPSCALER_FEED_FLUSH_EN
        , S_FLUSH = 3'd5
`endif
    } state_t;

    state_t            state_r;
    logic [CW-1:0]     col_r;
    logic [RW-1:0]     row_r;
    logic [PW-1:0]     phase_r;
    logic [ADDR_W-1:0] rd_addr_r;
    logic [23:0]       pixel_r;
    logic [23:0]       next_r;
    logic              pend_r;
    logic              busy_r;
    logic              done_r;

    logic flushing_s;
    logic valid_s;
    logic phase_last_s;
    logic col_last_s;
    logic last_px_s;
    logic prefetch_s;

`ifdef UPSCALER_FEED_FLUSH_EN
    assign flushing_s = (state_r == S_FLUSH);
`else
    assign flushing_s = 1'b0;
`endif

    assign valid_s      = ((state_r == S_EMIT) || flushing_s) && !stall;
    assign phase_last_s = (phase_r == PH_LAST);
    assign col_last_s   = (col_r == COL_LAST);
    assign last_px_s    = col_last_s && (row_r == ROW_LAST);
    // One read per source pixel, issued on its first valid phase so data is ready before the wrap.
    assign prefetch_s   = (state_r == S_EMIT) && !stall && (phase_r == {PW{1'b0}}) && !last_px_s;

    assign mem_rd_en   = (state_r == S_FETCH) || prefetch_s;
    assign mem_addr    = rd_addr_r;
    assign pixel_out   = pixel_r;
    assign pixel_valid = valid_s;
    assign sof         = valid_s && (state_r == S_EMIT) && (col_r == {CW{1'b0}}) && (row_r == {RW{1'b0}});
    assign eol         = valid_s && col_last_s;
    assign busy        = busy_r;
    assign done        = done_r;

    // Frame sequencer, raster counters, read address and pixel pipeline.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r   <= S_IDLE;
            col_r     <= {CW{1'b0}};
            row_r     <= {RW{1'b0}};
            phase_r   <= {PW{1'b0}};
            rd_addr_r <= {ADDR_W{1'b0}};
            pixel_r   <= 24'h000000;
            next_r    <= 24'h000000;
            pend_r    <= 1'b0;
            busy_r    <= 1'b0;
            done_r    <= 1'b0;
        end else begin
            done_r <= 1'b0;
            pend_r <= prefetch_s;
            if (pend_r) begin
                next_r <= mem_rd_data;
            end
            if (prefetch_s) begin
                rd_addr_r <= rd_addr_r + ADDR_W'(1);
            end
            case (state_r)
                S_IDLE: begin
                    if (start) begin
                        state_r <= S_FETCH;
                        busy_r  <= 1'b1;
                        col_r   <= {CW{1'b0}};
                        row_r   <= {RW{1'b0}};
                        phase_r <= {PW{1'b0}};
                    end
                end
                S_FETCH: begin
                    rd_addr_r <= ADDR_W'(1);
                    state_r   <= S_WAIT;
                end
                S_WAIT: begin
                    pixel_r <= mem_rd_data;
                    state_r <= S_EMIT;
                end
                S_EMIT: begin
                    if (!stall) begin
                        if (!phase_last_s) begin
                            phase_r <= phase_r + PW'(1);
                        end else begin
                            phase_r <= {PW{1'b0}};
                            if (last_px_s) begin
                                col_r   <= {CW{1'b0}};
                                row_r   <= {RW{1'b0}};
                                pixel_r <= 24'h000000;
`ifdef UPSCALER_FEED_FLUSH_EN
                                state_r <= S_FLUSH;
`else
                                state_r <= S_DONE;
                                done_r  <= 1'b1;
`endif
                            end else begin
                                // A read issued one cycle earlier has not reached next_r yet.
                                pixel_r <= pend_r ? mem_rd_data : next_r;
                                if (col_last_s) begin
                                    col_r <= {CW{1'b0}};
                                    row_r <= row_r + RW'(1);
                                end else begin
                                    col_r <= col_r + CW'(1);
                                end
                            end
                        end
                    end
                end
`ifdef UPSCALER_FEED_FLUSH_EN
                S_FLUSH: begin
                    if (!stall) begin
                        if (!phase_last_s) begin
                            phase_r <= phase_r + PW'(1);
                        end else begin
                            phase_r <= {PW{1'b0}};
                            if (col_last_s && (row_r == FL_LAST)) begin
                                state_r <= S_DONE;
                                done_r  <= 1'b1;
                            end else if (col_last_s) begin
                                col_r <= {CW{1'b0}};
                                row_r <= row_r + RW'(1);
                            end else begin
                                col_r <= col_r + CW'(1);
                            end
                        end
                    end
                end
`endif
                S_DONE: begin
                    state_r   <= S_IDLE;
                    busy_r    <= 1'b0;
                    rd_addr_r <= {ADDR_W{1'b0}};
                end
                default: begin
                    state_r <= S_IDLE;
                    busy_r  <= 1'b0;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_upscaler_pixel_feeder.sv
// Directed bench for upscaler_pixel_feeder (4x2 frame, 3 phases) with a queue-based raster model.
module tb_upscaler_pixel_feeder;
    localparam int W  = 4;
    localparam int H  = 2;
    localparam int P  = 3;
    localparam int AW = 3;
    localparam int FR = 3;
`ifdef UPSCALER_FEED_FLUSH_EN
    localparam int EXP_V   = W * H * P + FR * W * P;
    localparam int EXP_EOL = 2 * P + FR * P;
`else
    localparam int EXP_V   = W * H * P;
    localparam int EXP_EOL = 2 * P;
`endif

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          start = 1'b0;
    logic          stall = 1'b0;
    logic          mem_rd_en;
    logic [AW-1:0] mem_addr;
    logic [23:0]   mem_rd_data = 24'h000000;
    logic [23:0]   pixel_out;
    logic          pixel_valid, sof, eol, busy, done;

    upscaler_pixel_feeder #(.IMG_W(W), .IMG_H(H), .H_PHASES(P), .ADDR_W(AW), .FLUSH_ROWS(FR)) dut (
        .clk(clk), .rst(rst), .start(start), .stall(stall),
        .mem_rd_en(mem_rd_en), .mem_addr(mem_addr), .mem_rd_data(mem_rd_data),
        .pixel_out(pixel_out), .pixel_valid(pixel_valid), .sof(sof), .eol(eol),
        .busy(busy), .done(done)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [23:0] px;
        logic        sof;
        logic        eol;
    } exp_t;

    exp_t exp_q[$];
    int   rd_addr_q[$];
    int   pass_cnt = 0, chk_cnt = 0;
    int   vcount = 0, sof_cnt = 0, eol_cnt = 0, done_cnt = 0, rd_cnt = 0;
    int   cyc = 0, last_v_cyc = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        chk_cnt++;
        if (act === exp) pass_cnt++;
        else $display("FAIL %s: got %0h expected %0h", name, act, exp);
    endtask

    // Frame memory: word n holds n, one-cycle read latency.
    always @(posedge clk) begin
        cyc <= cyc + 1;
        if (mem_rd_en) begin
            mem_rd_data <= 24'(mem_addr);
            rd_cnt      <= rd_cnt + 1;
            rd_addr_q.push_back(int'(mem_addr));
        end
    end

    // Expected valid-cycle stream derived from raster order and the phase count.
    task automatic new_frame();
        exp_t e;
        exp_q.delete();
        rd_addr_q.delete();
        vcount = 0; sof_cnt = 0; eol_cnt = 0; done_cnt = 0; rd_cnt = 0;
        for (int n = 0; n < W * H; n++)
            for (int p = 0; p < P; p++) begin
                e.px = 24'(n); e.sof = (n == 0); e.eol = ((n % W) == W - 1);
                exp_q.push_back(e);
            end
`ifdef UPSCALER_FEED_FLUSH_EN
        for (int r = 0; r < FR; r++)
            for (int c = 0; c < W; c++)
                for (int p = 0; p < P; p++) begin
                    e.px = 24'h000000; e.sof = 1'b0; e.eol = (c == W - 1);
                    exp_q.push_back(e);
                end
`endif
    endtask

    // Compare process: every cycle out of reset.
    always @(negedge clk) begin
        exp_t e;
        if (!rst) begin
            if (pixel_valid) begin
                check("stream_len", 32'(exp_q.size() != 0), 32'd1);
                if (exp_q.size() != 0) begin
                    e = exp_q.pop_front();
                    check("pixel", pixel_out, e.px);
                    check("sof", sof, e.sof);
                    check("eol", eol, e.eol);
                end
                vcount++;
                if (sof) sof_cnt++;
                if (eol) eol_cnt++;
                last_v_cyc = cyc;
            end else begin
                check("flag_gate", {sof, eol}, 2'b00);
            end
            if (done) begin
                done_cnt++;
                check("done_timing", cyc - last_v_cyc, 1);
                check("done_q_empty", exp_q.size(), 0);
            end
            check("rd_outside_busy", mem_rd_en & ~busy, 1'b0);
        end
    end

    task automatic run_frame(input int stall_at, input int restart_at);
        int stall_left = 0;
        bit stalled = 0, got_done = 0;
        new_frame();
        @(posedge clk); #1 start = 1'b1;
        for (int i = 1; i < 400 && !got_done; i++) begin
            @(posedge clk); #1;
            start = (restart_at >= 0) && (vcount == restart_at);
            if (!stalled && vcount == stall_at) begin stall_left = 5; stalled = 1; end
            stall = (stall_left > 0);
            @(negedge clk);
            if (i == 1) begin
                check("lat_c1_rd", mem_rd_en, 1'b1);
                check("lat_c1_addr", mem_addr, 3'd0);
                check("lat_c1_busy", busy, 1'b1);
            end
            if (i == 2) check("lat_c2_valid", pixel_valid, 1'b0);
            if (i == 3) begin
                check("lat_c3_valid", pixel_valid, 1'b1);
                check("lat_c3_pixel", pixel_out, 24'h000000);
                check("lat_c3_sof", sof, 1'b1);
                check("lat_c3_prefetch_addr", mem_addr, 3'd1);
            end
            if (stall_left > 0) begin
                check("stall_valid", pixel_valid, 1'b0);
                check("stall_hold", pixel_out, 24'(stall_at / P));
                stall_left--;
            end
            if (done) got_done = 1;
        end
        start = 1'b0; stall = 1'b0;
        check("done_seen", got_done, 1'b1);
        @(negedge clk);
        check("busy_after_done", busy, 1'b0);
        check("done_one_cycle", done, 1'b0);
        repeat (3) @(negedge clk);
        check("done_count", done_cnt, 1);
        check("idle_busy", busy, 1'b0);
        check("valid_count", vcount, EXP_V);
        check("sof_count", sof_cnt, 3);
        check("eol_count", eol_cnt, EXP_EOL);
        check("read_count", rd_cnt, 8);
        for (int k = 0; k < rd_addr_q.size(); k++) check("read_addr", rd_addr_q[k], k);
    endtask

    initial begin
        int guard = 0;
        repeat (2) @(posedge clk);
        #1;
        check("rst_valid", pixel_valid, 1'b0);
        check("rst_busy", busy, 1'b0);
        check("rst_done", done, 1'b0);
        check("rst_rd_en", mem_rd_en, 1'b0);
        check("rst_addr", mem_addr, 3'd0);
        check("rst_pixel", pixel_out, 24'h000000);
        check("rst_flags", {sof, eol}, 2'b00);
        rst = 1'b0;

        run_frame(-1, -1);   // plain frame
        run_frame(7, -1);    // stall at phase 1 of pixel 2, read in flight
        run_frame(9, -1);    // stall at phase 0 of pixel 3, prefetch deferred
        run_frame(-1, 5);    // start while busy is ignored

        // Reset partway through row 1.
        new_frame();
        @(posedge clk); #1 start = 1'b1;
        @(posedge clk); #1 start = 1'b0;
        while (vcount < 14 && guard < 100) begin @(negedge clk); guard++; end
        check("abort_reached", vcount, 14);
        @(posedge clk); #1 rst = 1'b1;
        #1;
        check("abort_valid", pixel_valid, 1'b0);
        check("abort_busy", busy, 1'b0);
        check("abort_done", done, 1'b0);
        check("abort_rd_en", mem_rd_en, 1'b0);
        check("abort_addr", mem_addr, 3'd0);
        check("abort_pixel", pixel_out, 24'h000000);
        @(posedge clk); #1 rst = 1'b0;
        repeat (3) @(negedge clk);
        check("abort_no_done", done_cnt, 0);
        run_frame(-1, -1);   // replay from address 0

        $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
        $finish;
    end
endmodule
